// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32IM execute stage: datapath width,
// ALU operation encodings and divider state encoding.
package ex_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SRL    = 5'd3,
        OP_SRA    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_XOR    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_PASSB  = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Decode/pipectrl -> execute -> memory-stage signal bundle.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic            stall_i;
    logic            flush_i;
    alu_op_e         alu_op_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [XLEN-1:0] store_data_i;
    logic [4:0]      rd_addr_i;
    logic            rd_we_i;
    logic            mem_re_i;
    logic            mem_we_i;
    logic [2:0]      opfunc3_i;

    logic            stall_req_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_re_o;
    logic            mem_we_o;
    logic [2:0]      opfunc3_o;

    modport master (
        output stall_i, flush_i, alu_op_i, op_a_i, op_b_i, store_data_i,
               rd_addr_i, rd_we_i, mem_re_i, mem_we_i, opfunc3_i,
        input  stall_req_o, rd_addr_o, rd_data_o, rd_we_o, mem_addr_o,
               mem_re_o, mem_we_o, opfunc3_o
    );

    modport slave (
        input  stall_i, flush_i, alu_op_i, op_a_i, op_b_i, store_data_i,
               rd_addr_i, rd_we_i, mem_re_i, mem_we_i, opfunc3_i,
        output stall_req_o, rd_addr_o, rd_data_o, rd_we_o, mem_addr_o,
               mem_re_o, mem_we_o, opfunc3_o
    );

endinterface

// File: rtl/ex_divider.sv
// Iterative 32-step restoring divider for DIV/DIVU/REM/REMU with
// zero-divisor and signed-overflow results produced without iterating.
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_start,
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic [XLEN-1:0] o_result
);

    div_state_e      r_state, w_next;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic            r_q_neg, r_r_neg, r_is_rem;

    logic            w_signed, w_is_rem, w_div0, w_ovf, w_special;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
    logic [XLEN:0]   w_sh, w_diff;

    assign w_signed  = (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_is_rem  = (i_op == OP_REM) || (i_op == OP_REMU);
    assign w_div0    = (i_b == '0);
    assign w_ovf     = w_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;
    assign w_a_neg   = w_signed & i_a[XLEN-1];
    assign w_b_neg   = w_signed & i_b[XLEN-1];
    assign w_a_mag   = w_a_neg ? -i_a : i_a;
    assign w_b_mag   = w_b_neg ? -i_b : i_b;

    // Restoring step: shift next dividend bit into the partial remainder, trial-subtract.
    assign w_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_sh - {1'b0, r_dvs};
    assign w_q_fix = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix = r_r_neg ? -r_rem : r_rem;

    assign o_busy = ((r_state == DIV_IDLE) && i_start && !w_special) || (r_state == DIV_BUSY);

    always_comb begin
        o_result = '0;
        if (r_state == DIV_DONE)
            o_result = r_is_rem ? w_r_fix : w_q_fix;
        else if (w_is_rem)
            o_result = w_div0 ? i_a : '0;
        else
            o_result = w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= DIV_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: if (i_start && !w_special) w_next = DIV_BUSY;
            DIV_BUSY: if (r_cnt == 5'd31)        w_next = DIV_DONE;
            DIV_DONE: if (!i_stall)              w_next = DIV_IDLE;
            default:                             w_next = DIV_IDLE;
        endcase
        if (i_flush) w_next = DIV_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (r_state == DIV_IDLE) begin
            if (i_start && !w_special) begin
                r_cnt    <= '0;
                r_rem    <= '0;
                r_quo    <= w_a_mag;
                r_dvs    <= w_b_mag;
                r_q_neg  <= w_a_neg ^ w_b_neg;
                r_r_neg  <= w_a_neg;
                r_is_rem <= w_is_rem;
            end
        end else if (r_state == DIV_BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_diff[XLEN]) begin
                r_rem <= w_diff[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_sh[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: inline ALU and 33x33 multiplier, address generation,
// iterative divider, and the registered hand-off to the memory stage.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);

    logic            w_is_div, w_stall_req, w_ma_sgn, w_mb_sgn;
    logic [XLEN-1:0] w_a, w_b, w_res, w_div_res, w_addr, w_rd_data;
    logic [63:0]     w_ma, w_mb, w_prod;

    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_data, r_mem_addr;
    logic            r_rd_we, r_mem_re, r_mem_we;
    logic [2:0]      r_opfunc3;

    assign w_a      = bus.op_a_i;
    assign w_b      = bus.op_b_i;
    assign w_is_div = bus.alu_op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    // Operands widened to 33-bit signed; the 64-bit product is exact for every MUL variant.
    assign w_ma_sgn = (bus.alu_op_i == OP_MULH || bus.alu_op_i == OP_MULHSU) & w_a[XLEN-1];
    assign w_mb_sgn = (bus.alu_op_i == OP_MULH) & w_b[XLEN-1];
    assign w_ma     = {{32{w_ma_sgn}}, w_a};
    assign w_mb     = {{32{w_mb_sgn}}, w_b};
    assign w_prod   = w_ma * w_mb;

    assign w_addr    = w_a + w_b;
    assign w_rd_data = bus.mem_we_i ? bus.store_data_i : w_res;

    ex_divider u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_flush  (bus.flush_i),
        .i_stall  (bus.stall_i),
        .i_start  (w_is_div),
        .i_op     (bus.alu_op_i),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_busy   (w_stall_req),
        .o_result (w_div_res)
    );

    always_comb begin
        w_res = '0;
        case (bus.alu_op_i)
            OP_ADD:    w_res = w_a + w_b;
            OP_SUB:    w_res = w_a - w_b;
            OP_SLL:    w_res = w_a << w_b[4:0];
            OP_SRL:    w_res = w_a >> w_b[4:0];
            OP_SRA:    w_res = $unsigned($signed(w_a) >>> w_b[4:0]);
            OP_SLT:    w_res = {31'b0, $signed(w_a) < $signed(w_b)};
            OP_SLTU:   w_res = {31'b0, w_a < w_b};
            OP_XOR:    w_res = w_a ^ w_b;
            OP_OR:     w_res = w_a | w_b;
            OP_AND:    w_res = w_a & w_b;
            OP_PASSB:  w_res = w_b;
            OP_MUL:    w_res = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[63:32];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_res = w_div_res;
            default:   w_res = '0;
        endcase
    end

    // Flush and divider-stall both bubble the control bits; stall_i freezes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_rd_we    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_opfunc3  <= '0;
        end else if (!bus.stall_i) begin
            if (w_stall_req) begin
                r_rd_we  <= 1'b0;
                r_mem_re <= 1'b0;
                r_mem_we <= 1'b0;
            end else begin
                r_rd_addr  <= bus.rd_addr_i;
                r_rd_data  <= w_rd_data;
                r_rd_we    <= bus.rd_we_i;
                r_mem_addr <= w_addr;
                r_mem_re   <= bus.mem_re_i;
                r_mem_we   <= bus.mem_we_i;
                r_opfunc3  <= bus.opfunc3_i;
            end
        end
    end

    assign bus.stall_req_o = w_stall_req;
    assign bus.rd_addr_o   = r_rd_addr;
    assign bus.rd_data_o   = r_rd_data;
    assign bus.rd_we_o     = r_rd_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_re_o    = r_mem_re;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.opfunc3_o   = r_opfunc3;

endmodule
